data_memory_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port data memory (64-bit address/data, write on clock edge, combinational read).
- Accepts load/store requests from port A (datapath load/store unit) and port B (debug/DMA loader).
- Grants round-robin, drives the memory control signals for exactly one access cycle, and returns read data with a one-cycle acknowledge pulse.

---
 rtl/data_memory_arbiter_pkg.sv | 13 +
 rtl/data_memory_arbiter_if.sv | 44 ++++
 rtl/rr_arbiter_2.sv | 22 ++
 rtl/data_memory_arbiter.sv | 106 ++++++++++
 tb/tb_data_memory_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter and its round-robin grant logic.
package data_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Bundle of the two requester ports plus the single-port data memory bus.
interface data_memory_arbiter_if #(
    parameter int AddressWidth = 64,
    parameter int DataWidth    = 64
);
    logic                    ReqA;
    logic                    WriteA;
    logic [AddressWidth-1:0] AddressA;
    logic [DataWidth-1:0]    WriteDataA;
    logic                    AckA;

    logic                    ReqB;
    logic                    WriteB;
    logic [AddressWidth-1:0] AddressB;
    logic [DataWidth-1:0]    WriteDataB;
    logic                    AckB;

    logic [DataWidth-1:0]    ReadData;

    logic [AddressWidth-1:0] MemAddress;
    logic [DataWidth-1:0]    MemWriteData;
    logic                    MemWrite;
    logic                    MemRead;
    logic [DataWidth-1:0]    MemReadData;

    // Arbiter side: consumes requests and memory read data.
    modport slave (
        input  ReqA, WriteA, AddressA, WriteDataA,
        input  ReqB, WriteB, AddressB, WriteDataB,
        input  MemReadData,
        output AckA, AckB, ReadData,
        output MemAddress, MemWriteData, MemWrite, MemRead
    );

    // Environment side: requesters and memory.
    modport master (
        output ReqA, WriteA, AddressA, WriteDataA,
        output ReqB, WriteB, AddressB, WriteDataB,
        output MemReadData,
        input  AckA, AckB, ReadData,
        input  MemAddress, MemWriteData, MemWrite, MemRead
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the priority side.
module rr_arbiter_2
    import data_memory_arbiter_pkg::*;
(
    input  logic reqA,
    input  logic reqB,
    input  logic priorityPort,
    output logic grant,
    output logic owner
);

    always_comb begin
        grant = reqA | reqB;
        owner = priorityPort;
        if (reqA && !reqB) begin
            owner = PORT_A;
        end else if (reqB && !reqA) begin
            owner = PORT_B;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin sequencer sharing one data memory between the load/store unit (A) and the loader (B).
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int AddressWidth = 64,
    parameter int DataWidth    = 64
) (
    input  logic                   Clock,
    input  logic                   ResetN,
    data_memory_arbiter_if.slave   bus
);

    state_t                  state;
    logic                    rrPriority;
    logic                    ownerReg;
    logic                    grant;
    logic                    owner;

    logic                    memWrite;
    logic                    memRead;
    logic [AddressWidth-1:0] memAddress;
    logic [DataWidth-1:0]    memWriteData;
    logic                    ackA;
    logic                    ackB;
    logic [DataWidth-1:0]    readData;

    logic                    selWrite;
    logic [AddressWidth-1:0] selAddress;
    logic [DataWidth-1:0]    selWriteData;

    rr_arbiter_2 u_arbiter (
        .reqA         (bus.ReqA),
        .reqB         (bus.ReqB),
        .priorityPort (rrPriority),
        .grant        (grant),
        .owner        (owner)
    );

    assign selWrite     = (owner == PORT_B) ? bus.WriteB     : bus.WriteA;
    assign selAddress   = (owner == PORT_B) ? bus.AddressB   : bus.AddressA;
    assign selWriteData = (owner == PORT_B) ? bus.WriteDataB : bus.WriteDataA;

    // Requests are only looked at in IDLE, so the winner's values are frozen into the Mem* registers there.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state        <= IDLE;
            rrPriority   <= PORT_A;
            ownerReg     <= PORT_A;
            memWrite     <= 1'b0;
            memRead      <= 1'b0;
            memAddress   <= '0;
            memWriteData <= '0;
            ackA         <= 1'b0;
            ackB         <= 1'b0;
            readData     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        memAddress   <= selAddress;
                        memWriteData <= selWriteData;
                        memWrite     <= selWrite;
                        memRead      <= ~selWrite;
                        ownerReg     <= owner;
                        state        <= ACCESS;
                    end else begin
                        memWrite <= 1'b0;
                        memRead  <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (memRead) begin
                        readData <= bus.MemReadData;
                    end
                    memWrite <= 1'b0;
                    memRead  <= 1'b0;
                    ackA     <= (ownerReg == PORT_A);
                    ackB     <= (ownerReg == PORT_B);
                    state    <= DONE;
                end
                DONE: begin
                    ackA       <= 1'b0;
                    ackB       <= 1'b0;
                    rrPriority <= ~ownerReg;
                    state      <= IDLE;
                end
                default: begin
                    memWrite <= 1'b0;
                    memRead  <= 1'b0;
                    ackA     <= 1'b0;
                    ackB     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.MemAddress   = memAddress;
    assign bus.MemWriteData = memWriteData;
    assign bus.MemWrite     = memWrite;
    assign bus.MemRead      = memRead;
    assign bus.AckA         = ackA;
    assign bus.AckB         = ackB;
    assign bus.ReadData     = readData;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench: per-port requester drivers, a behavioural memory and an in-order scoreboard.
module tb_data_memory_arbiter;

    typedef struct {
        logic        port;
        logic        write;
        logic [63:0] addr;
        logic [63:0] data;
        logic [63:0] expRead;
        logic        abortOnReset;
    } txn_t;

    logic        Clock = 1'b0;
    logic        ResetN;
    logic [63:0] mem [0:65535];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    txn_t        qA[$];
    txn_t        qB[$];
    txn_t        expQ[$];
    int          accessLog[$];
    logic        busyA = 1'b0;
    logic        busyB = 1'b0;

    txn_t        vectors [0:6];

    data_memory_arbiter_if bus ();

    data_memory_arbiter dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    assign bus.MemReadData = mem[bus.MemAddress[15:0]];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic txn_t mk(input logic port, input logic write, input logic [63:0] addr,
                                input logic [63:0] data, input logic [63:0] expRead, input logic abortOnReset);
        txn_t t;
        t.port = port;
        t.write = write;
        t.addr = addr;
        t.data = data;
        t.expRead = expRead;
        t.abortOnReset = abortOnReset;
        return t;
    endfunction

    task automatic applyStimulus(input txn_t t);
        if (t.port) qB.push_back(t);
        else        qA.push_back(t);
        expQ.push_back(t);
    endtask

    task automatic waitIdle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (qA.size() == 0 && qB.size() == 0 && expQ.size() == 0 && !busyA && !busyB) begin
                done = 1'b1;
                break;
            end
            @(posedge Clock);
            #1;
        end
        if (!done) checkOutput({name, "_timeout"}, 64'd1, 64'd0);
        repeat (2) @(posedge Clock);
        #1;
    endtask

    task automatic waitForAccess(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clock);
            #1;
            if (bus.MemWrite || bus.MemRead) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    initial begin
        int   logStart;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        ResetN = 1'b0;
        bus.ReqA = 1'b0; bus.WriteA = 1'b0; bus.AddressA = '0; bus.WriteDataA = '0;
        bus.ReqB = 1'b0; bus.WriteB = 1'b0; bus.AddressB = '0; bus.WriteDataB = '0;

        vectors[0] = mk(1'b0, 1'b1, 64'd13, 64'd12345, 64'd0, 1'b0);
        vectors[1] = mk(1'b0, 1'b0, 64'd13, 64'd0, 64'd12345, 1'b0);
        vectors[2] = mk(1'b1, 1'b1, 64'hDEAD_BEEF_0000_0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        vectors[3] = mk(1'b1, 1'b0, 64'hDEAD_BEEF_0000_0100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        vectors[4] = mk(1'b0, 1'b0, 64'hDEAD_BEEF_0000_0100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        vectors[5] = mk(1'b0, 1'b1, 64'd7, 64'd0, 64'd0, 1'b0);
        vectors[6] = mk(1'b1, 1'b0, 64'd7, 64'd0, 64'd0, 1'b0);

        fork
            forever begin
                @(posedge Clock);
                cyc = cyc + 1;
                if (bus.MemWrite) mem[bus.MemAddress[15:0]] <= bus.MemWriteData;
            end
            forever begin
                @(negedge Clock);
                if (!ResetN && busyA && qA[0].abortOnReset) begin qA.delete(0); busyA = 1'b0; end
                if (bus.AckA && busyA) begin qA.delete(0); busyA = 1'b0; end
                if (!busyA) begin
                    if (qA.size() > 0) begin
                        bus.ReqA = 1'b1; bus.WriteA = qA[0].write;
                        bus.AddressA = qA[0].addr; bus.WriteDataA = qA[0].data;
                        busyA = 1'b1;
                    end else begin
                        bus.ReqA = 1'b0;
                    end
                end
            end
            forever begin
                @(negedge Clock);
                if (!ResetN && busyB && qB[0].abortOnReset) begin qB.delete(0); busyB = 1'b0; end
                if (bus.AckB && busyB) begin qB.delete(0); busyB = 1'b0; end
                if (!busyB) begin
                    if (qB.size() > 0) begin
                        bus.ReqB = 1'b1; bus.WriteB = qB[0].write;
                        bus.AddressB = qB[0].addr; bus.WriteDataB = qB[0].data;
                        busyB = 1'b1;
                    end else begin
                        bus.ReqB = 1'b0;
                    end
                end
            end
            begin : monitor
                logic        prevMem;
                logic        prevAck;
                logic        headAccessed;
                int          accessCyc;
                logic [63:0] expHeld;
                prevMem = 1'b0; prevAck = 1'b0; headAccessed = 1'b0; accessCyc = 0; expHeld = '0;
                forever begin
                    @(negedge Clock);
                    if (!ResetN) expHeld = '0;
                    if (bus.MemWrite || bus.MemRead) begin
                        if (prevMem) checkOutput("memOneCycle", 64'd1, 64'd0);
                        if (expQ.size() == 0) begin
                            checkOutput("unexpectedAccess", 64'd1, 64'd0);
                        end else begin
                            checkOutput("memWrite", {63'd0, bus.MemWrite}, {63'd0, expQ[0].write});
                            checkOutput("memRead", {63'd0, bus.MemRead}, {63'd0, ~expQ[0].write});
                            checkOutput("memAddress", bus.MemAddress, expQ[0].addr);
                            checkOutput("memWriteData", bus.MemWriteData, expQ[0].data);
                            accessCyc = cyc;
                            accessLog.push_back(cyc);
                            headAccessed = 1'b1;
                        end
                    end
                    if (!ResetN && expQ.size() > 0 && expQ[0].abortOnReset && headAccessed) begin
                        expQ.delete(0);
                        headAccessed = 1'b0;
                    end
                    if (bus.AckA || bus.AckB) begin
                        if (prevAck) checkOutput("ackOneCycle", 64'd1, 64'd0);
                        if (bus.AckA && bus.AckB) checkOutput("ackBoth", 64'd1, 64'd0);
                        if (expQ.size() == 0 || !headAccessed) begin
                            checkOutput("unexpectedAck", 64'd1, 64'd0);
                        end else begin
                            checkOutput("ackPort", {63'd0, bus.AckB}, {63'd0, expQ[0].port});
                            checkOutput("ackLatency", 64'(cyc - accessCyc), 64'd1);
                            if (!expQ[0].write) expHeld = expQ[0].expRead;
                            checkOutput("readData", bus.ReadData, expHeld);
                            expQ.delete(0);
                            headAccessed = 1'b0;
                        end
                    end
                    prevMem = bus.MemWrite | bus.MemRead;
                    prevAck = bus.AckA | bus.AckB;
                end
            end
        join_none

        // Reset held with both ports requesting; A must win first once released.
        applyStimulus(mk(1'b0, 1'b1, 64'd5, 64'h55, 64'd0, 1'b0));
        applyStimulus(mk(1'b1, 1'b0, 64'd5, 64'd0, 64'h55, 1'b0));
        repeat (2) @(posedge Clock);
        #1;
        checkOutput("rstAckA", {63'd0, bus.AckA}, 64'd0);
        checkOutput("rstAckB", {63'd0, bus.AckB}, 64'd0);
        checkOutput("rstMemWrite", {63'd0, bus.MemWrite}, 64'd0);
        checkOutput("rstMemRead", {63'd0, bus.MemRead}, 64'd0);
        checkOutput("rstMemAddress", bus.MemAddress, 64'd0);
        checkOutput("rstMemWriteData", bus.MemWriteData, 64'd0);
        checkOutput("rstReadData", bus.ReadData, 64'd0);
        ResetN = 1'b1;
        waitIdle("resetRelease");

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vectors[i]);
            waitIdle("vector");
        end

        // Contention: both ports keep requesting, service must alternate A, B, A, B.
        applyStimulus(mk(1'b0, 1'b1, 64'd1 << 14, 64'd1 << 63, 64'd0, 1'b0));
        applyStimulus(mk(1'b1, 1'b0, 64'd1, 64'd0, 64'd0, 1'b0));
        applyStimulus(mk(1'b0, 1'b0, 64'd1 << 14, 64'd0, 64'h8000_0000_0000_0000, 1'b0));
        applyStimulus(mk(1'b1, 1'b1, 64'd1, 64'd99, 64'd0, 1'b0));
        waitIdle("contention");

        logStart = accessLog.size();
        applyStimulus(mk(1'b0, 1'b1, 64'd30, 64'd1, 64'd0, 1'b0));
        applyStimulus(mk(1'b0, 1'b1, 64'd31, 64'd2, 64'd0, 1'b0));
        applyStimulus(mk(1'b0, 1'b0, 64'd30, 64'd0, 64'd1, 1'b0));
        waitIdle("backToBack");
        if (accessLog.size() >= logStart + 3) begin
            checkOutput("b2bSpacing1", 64'(accessLog[logStart+1] - accessLog[logStart]), 64'd3);
            checkOutput("b2bSpacing2", 64'(accessLog[logStart+2] - accessLog[logStart+1]), 64'd3);
        end else begin
            checkOutput("b2bAccessCount", 64'(accessLog.size() - logStart), 64'd3);
        end

        // B raises its request while A is already in its access cycle.
        logStart = accessLog.size();
        applyStimulus(mk(1'b0, 1'b0, 64'd13, 64'd0, 64'd12345, 1'b0));
        waitForAccess("lateB");
        applyStimulus(mk(1'b1, 1'b1, 64'd20, 64'hBEEF, 64'd0, 1'b0));
        waitIdle("lateB");
        if (accessLog.size() >= logStart + 2) begin
            checkOutput("lateBSpacing", 64'(accessLog[logStart+1] - accessLog[logStart]), 64'd3);
        end else begin
            checkOutput("lateBAccessCount", 64'(accessLog.size() - logStart), 64'd2);
        end
        applyStimulus(mk(1'b0, 1'b0, 64'd20, 64'd0, 64'hBEEF, 1'b0));
        waitIdle("lateBReadback");

        // Reset lands on the edge that closes a store's access cycle.
        applyStimulus(mk(1'b0, 1'b1, 64'd1, 64'd77, 64'd0, 1'b1));
        waitForAccess("midReset");
        ResetN = 1'b0;
        @(posedge Clock);
        #1;
        checkOutput("midResetAckA", {63'd0, bus.AckA}, 64'd0);
        checkOutput("midResetReadData", bus.ReadData, 64'd0);
        checkOutput("midResetMemWrite", {63'd0, bus.MemWrite}, 64'd0);
        @(posedge Clock);
        #1;
        ResetN = 1'b1;
        checkOutput("midResetMemContent", mem[1], 64'd77);
        waitIdle("midResetSettle");
        applyStimulus(mk(1'b0, 1'b0, 64'd1, 64'd0, 64'd77, 1'b0));
        waitIdle("midResetReadback");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
